// File: rtl/mips_pkg.sv
// Shared types and defaults for the MEM/WB stage: FSM encoding, widths and
// a small address-alignment helper.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int CNT_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory (slave).
interface mem_wb_stage_if #(
  parameter int DATA_W = mips_pkg::DATA_W_DEF
);

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: clears to a bubble when bubble_i is set,
// otherwise captures its inputs when load_i is set and holds them otherwise.
module mem_wb_reg #(
  parameter int DATA_W = mips_pkg::DATA_W_DEF,
  parameter int REG_W  = mips_pkg::REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [REG_W-1:0]  dest_i,
  output logic              valid_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [REG_W-1:0]  dest_o
);

  logic              valid_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic [DATA_W-1:0] read_data_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [REG_W-1:0]  dest_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      dest_q       <= '0;
    end else if (bubble_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      dest_q       <= '0;
    end else if (load_i) begin
      valid_q      <= valid_i;
      reg_write_q  <= reg_write_i;
      mem_to_reg_q <= mem_to_reg_i;
      read_data_q  <= read_data_i;
      alu_result_q <= alu_result_i;
      dest_q       <= dest_i;
    end
  end

  assign valid_o      = valid_q;
  assign reg_write_o  = reg_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign read_data_o  = read_data_q;
  assign alu_result_o = alu_result_q;
  assign dest_o       = dest_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: runs loads/stores on the request/ready bus,
// stalls upstream while an access is pending and resolves branches.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] Add,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  Mux,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              stall,
  mem_wb_stage_if.master    dmem,
  output logic              mem_err,
  output logic              wb_valid,
  output logic              RegWrite_Out,
  output logic              MemtoReg_Out,
  output logic [DATA_W-1:0] ReadData_Out,
  output logic [DATA_W-1:0] ALUResult_Out,
  output logic [REG_W-1:0]  Mux_Out
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_err_q, mem_err_d;

  logic              mem_op;
  logic              misal;
  logic              start;
  logic              timeout_hit;
  logic              wb_load;
  logic              wb_rw_en;
  logic [DATA_W-1:0] wb_rdata;

  assign mem_op      = in_valid & (MemRead | MemWrite);
  assign misal       = mem_op & is_misaligned(ALUResult[1:0]);
  assign start       = mem_op & ~misal;
  assign timeout_hit = (state_q == WAIT) & ~dmem.mem_ready
                     & (cnt_q == CNT_W'(TIMEOUT - 1));

  assign pcsrc         = Branch & Zero & in_valid;
  assign branch_target = Add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = WAIT;
      WAIT: if (dmem.mem_ready || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage outputs: stall, and what (if anything) MEM/WB captures this cycle.
  always_comb begin
    stall    = 1'b0;
    wb_load  = 1'b0;
    wb_rw_en = 1'b0;
    wb_rdata = '0;
    unique case (state_q)
      IDLE: begin
        stall    = start;
        wb_load  = in_valid & ~start;
        wb_rw_en = ~misal;
      end
      WAIT: begin
        stall    = ~dmem.mem_ready & ~timeout_hit;
        wb_load  = dmem.mem_ready | timeout_hit;
        wb_rw_en = dmem.mem_ready;
        if (dmem.mem_ready && !mem_we_q) wb_rdata = dmem.mem_rdata;
      end
      default: ;
    endcase
  end

  // Bus drive, WAIT counter and sticky error flag.
  always_comb begin
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = mem_err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite;
          mem_addr_d  = {ALUResult[DATA_W-1:2], 2'b00};
          mem_wdata_d = ReadData2;
          cnt_d       = '0;
        end
        if (misal) mem_err_d = 1'b1;
      end
      WAIT: begin
        if (dmem.mem_ready || timeout_hit) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (timeout_hit) mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign dmem.mem_req   = mem_req_q;
  assign dmem.mem_we    = mem_we_q;
  assign dmem.mem_addr  = mem_addr_q;
  assign dmem.mem_wdata = mem_wdata_q;
  assign mem_err        = mem_err_q;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (wb_load),
    .bubble_i     (~wb_load),
    .valid_i      (1'b1),
    .reg_write_i  (RegWrite & wb_rw_en),
    .mem_to_reg_i (MemtoReg),
    .read_data_i  (wb_rdata),
    .alu_result_i (ALUResult),
    .dest_i       (Mux),
    .valid_o      (wb_valid),
    .reg_write_o  (RegWrite_Out),
    .mem_to_reg_o (MemtoReg_Out),
    .read_data_o  (ReadData_Out),
    .alu_result_o (ALUResult_Out),
    .dest_o       (Mux_Out)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: constant vector table, randomized
// instructions against a transaction-level model, and hand-written corner sequences.
module tb_mem_wb_stage;

  localparam int TIMEOUT = 15;
  localparam int NEVER   = 99;

  typedef struct {
    logic        iv, br, zr, mr, mw, m2r, rw;
    logic [31:0] add, alu, wd;
    logic [4:0]  mux;
    int          k;          // WAIT-cycle index at which mem_ready is given
    logic [31:0] rdata;
    int          exp_stall;  // stall cycles; equals cycles with mem_req high
    logic        exp_valid, exp_rw;
    logic [31:0] exp_rd;
    logic        exp_err, exp_pcsrc;
  } vec_t;

  logic        clk, rst_n;
  logic        in_valid, Branch, Zero, MemRead, MemWrite, MemtoReg, RegWrite;
  logic [31:0] Add, ALUResult, ReadData2;
  logic [4:0]  Mux;
  logic        pcsrc, stall, mem_err, wb_valid, RegWrite_Out, MemtoReg_Out;
  logic [31:0] branch_target, ReadData_Out, ALUResult_Out;
  logic [4:0]  Mux_Out;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_stage_if #(.DATA_W(32)) dmem ();

  mem_wb_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .Branch        (Branch),
    .Zero          (Zero),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .Add           (Add),
    .ALUResult     (ALUResult),
    .ReadData2     (ReadData2),
    .Mux           (Mux),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .stall         (stall),
    .dmem          (dmem),
    .mem_err       (mem_err),
    .wb_valid      (wb_valid),
    .RegWrite_Out  (RegWrite_Out),
    .MemtoReg_Out  (MemtoReg_Out),
    .ReadData_Out  (ReadData_Out),
    .ALUResult_Out (ALUResult_Out),
    .Mux_Out       (Mux_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got 0x%0h, want 0x%0h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic iv, br, zr, mr, mw, m2r, rw,
    input logic [31:0] add, alu, wd, input logic [4:0] mux,
    input int k, input logic [31:0] rdata,
    input int exp_stall, input logic exp_valid, exp_rw,
    input logic [31:0] exp_rd, input logic exp_err, exp_pcsrc);
    vec_t v;
    v.iv = iv; v.br = br; v.zr = zr; v.mr = mr; v.mw = mw; v.m2r = m2r; v.rw = rw;
    v.add = add; v.alu = alu; v.wd = wd; v.mux = mux; v.k = k; v.rdata = rdata;
    v.exp_stall = exp_stall; v.exp_valid = exp_valid; v.exp_rw = exp_rw;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_pcsrc = exp_pcsrc;
    return v;
  endfunction

  // Transaction-level reference: outcome of one instruction from the stage's rules.
  function automatic void model(inout vec_t v, inout logic err);
    logic is_mem, bad, tmo, ok;
    is_mem = v.iv && (v.mr || v.mw);
    bad    = is_mem && (v.alu[1:0] != 2'b00);
    tmo    = is_mem && !bad && (v.k > TIMEOUT - 1);
    ok     = is_mem && !bad && !tmo;
    v.exp_pcsrc = v.br && v.zr && v.iv;
    v.exp_valid = v.iv;
    v.exp_stall = (!is_mem || bad) ? 0 : (tmo ? TIMEOUT : v.k + 1);
    v.exp_rw    = v.iv && v.rw && !bad && !tmo;
    v.exp_rd    = (ok && v.mr && !v.mw) ? v.rdata : 32'h0;
    err         = err || bad || tmo;
    v.exp_err   = err;
  endfunction

  task automatic clear_inputs();
    in_valid = 0; Branch = 0; Zero = 0; MemRead = 0; MemWrite = 0;
    MemtoReg = 0; RegWrite = 0; Add = 0; ALUResult = 0; ReadData2 = 0; Mux = 0;
  endtask

  // Present one instruction right after a rising edge, play the memory side,
  // and compare against the vector's expectations once the stage releases it.
  task automatic run_instr(input string tag, input vec_t v);
    int cyc, waits, stall_n, req_n;
    logic done, pc;
    logic [31:0] bt;
    in_valid = v.iv; Branch = v.br; Zero = v.zr; MemRead = v.mr; MemWrite = v.mw;
    MemtoReg = v.m2r; RegWrite = v.rw; Add = v.add; ALUResult = v.alu;
    ReadData2 = v.wd; Mux = v.mux;
    cyc = 0; waits = 0; stall_n = 0; req_n = 0; done = 0; pc = 0; bt = 0;
    while (!done && cyc < 40) begin
      if (dmem.mem_req) begin
        dmem.mem_ready = (waits == v.k);
        dmem.mem_rdata = (waits == v.k) ? v.rdata : $urandom;
        waits++;
      end else begin
        dmem.mem_ready = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) begin
        pc = pcsrc;
        bt = branch_target;
      end
      if (dmem.mem_req) begin
        req_n++;
        check(tag, "mem_addr", dmem.mem_addr, {v.alu[31:2], 2'b00});
        check(tag, "mem_we", {31'b0, dmem.mem_we}, {31'b0, v.mw});
        check(tag, "mem_wdata", dmem.mem_wdata, v.wd);
      end
      if (stall) stall_n++;
      else       done = 1'b1;
      cyc++;
      @(posedge clk);
      #1;
    end
    dmem.mem_ready = 1'b0;
    if (!done) check(tag, "completion_bound", 32'd0, 32'd1);
    check(tag, "stall_cycles", stall_n, v.exp_stall);
    check(tag, "req_cycles", req_n, v.exp_stall);
    check(tag, "pcsrc", {31'b0, pc}, {31'b0, v.exp_pcsrc});
    check(tag, "branch_target", bt, v.add);
    check(tag, "wb_valid", {31'b0, wb_valid}, {31'b0, v.exp_valid});
    check(tag, "RegWrite_Out", {31'b0, RegWrite_Out}, {31'b0, v.exp_rw});
    check(tag, "mem_err", {31'b0, mem_err}, {31'b0, v.exp_err});
    check(tag, "mem_req_after", {31'b0, dmem.mem_req}, 32'd0);
    if (v.exp_valid) begin
      check(tag, "ReadData_Out", ReadData_Out, v.exp_rd);
      check(tag, "ALUResult_Out", ALUResult_Out, v.alu);
      check(tag, "Mux_Out", {27'b0, Mux_Out}, {27'b0, v.mux});
      check(tag, "MemtoReg_Out", {31'b0, MemtoReg_Out}, {31'b0, v.m2r});
    end
  endtask

  vec_t tbl[8];
  vec_t v;
  logic model_err;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    dmem.mem_ready = 1'b0;
    dmem.mem_rdata = '0;

    //            iv br zr mr mw m2r rw add     alu     wd       mux k   rdata          stall v  rw rd             err pc
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 1, 32'h0,  32'h10, 32'h0,    5,  0,  32'h0,          0,   1, 1, 32'h0,          0, 0);
    tbl[1] = mk(1, 0, 0, 1, 0, 1, 1, 32'h0,  32'h40, 32'h0,    7,  2,  32'hDEADBEEF,   3,   1, 1, 32'hDEADBEEF,   0, 0);
    tbl[2] = mk(1, 0, 0, 0, 1, 0, 0, 32'h0,  32'h44, 32'h1234, 0,  0,  32'h0,          1,   1, 0, 32'h0,          0, 0);
    tbl[3] = mk(0, 0, 0, 1, 0, 1, 1, 32'h0,  32'h41, 32'h0,    3,  0,  32'h0,          0,   0, 0, 32'h0,          0, 0);
    tbl[4] = mk(1, 1, 1, 0, 0, 0, 0, 32'h80, 32'h0,  32'h0,    0,  0,  32'h0,          0,   1, 0, 32'h0,          0, 1);
    tbl[5] = mk(0, 1, 1, 0, 0, 0, 0, 32'h84, 32'h0,  32'h0,    0,  0,  32'h0,          0,   0, 0, 32'h0,          0, 0);
    tbl[6] = mk(1, 0, 0, 1, 0, 1, 1, 32'h0,  32'h48, 32'h0,    9,  0,  32'h5A5A0000,   1,   1, 1, 32'h5A5A0000,   0, 0);
    tbl[7] = mk(1, 0, 0, 1, 0, 1, 1, 32'h0,  32'h4C, 32'h0,    10, 14, 32'hCAFE0001,   15,  1, 1, 32'hCAFE0001,   0, 0);

    #12;
    check("reset", "mem_req", {31'b0, dmem.mem_req}, 32'd0);
    check("reset", "mem_err", {31'b0, mem_err}, 32'd0);
    check("reset", "wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset", "RegWrite_Out", {31'b0, RegWrite_Out}, 32'd0);
    check("reset", "ReadData_Out", ReadData_Out, 32'd0);
    check("reset", "ALUResult_Out", ALUResult_Out, 32'd0);
    check("reset", "stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_instr($sformatf("vec%0d", i), tbl[i]);

    model_err = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int kind;
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      kind  = $urandom_range(0, 2);
      v.iv  = ($urandom_range(0, 7) != 0);
      v.br  = $urandom_range(0, 1);
      v.zr  = $urandom_range(0, 1);
      v.mr  = (kind == 1);
      v.mw  = (kind == 2);
      v.m2r = (kind == 1);
      v.rw  = (kind != 2);
      v.add = $urandom;
      v.alu = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) v.alu[1:0] = 2'($urandom_range(1, 3));
      v.wd    = $urandom;
      v.mux   = 5'($urandom_range(0, 31));
      v.k     = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 5);
      v.rdata = $urandom;
      model(v, model_err);
      run_instr($sformatf("rnd%0d", i), v);
    end

    run_instr("misaligned", mk(1, 0, 0, 1, 0, 1, 1, 32'h0, 32'h41, 32'h0, 4, 0, 32'h0,
                                0, 1, 0, 32'h0, 1, 0));
    run_instr("timeout", mk(1, 0, 0, 1, 0, 1, 1, 32'h0, 32'h80, 32'h0, 6, NEVER, 32'h0,
                             TIMEOUT, 1, 0, 32'h0, 1, 0));

    // Reset asserted mid-WAIT must drop the pending store and clear everything at once.
    clear_inputs();
    in_valid = 1; MemWrite = 1; ALUResult = 32'h200; ReadData2 = 32'hA5A5;
    @(posedge clk);
    #1;
    check("rst_wait", "mem_req_before", {31'b0, dmem.mem_req}, 32'd1);
    check("rst_wait", "mem_we_before", {31'b0, dmem.mem_we}, 32'd1);
    @(posedge clk);
    #3;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_wait", "mem_req", {31'b0, dmem.mem_req}, 32'd0);
    check("rst_wait", "mem_we", {31'b0, dmem.mem_we}, 32'd0);
    check("rst_wait", "mem_addr", dmem.mem_addr, 32'd0);
    check("rst_wait", "mem_wdata", dmem.mem_wdata, 32'd0);
    check("rst_wait", "mem_err", {31'b0, mem_err}, 32'd0);
    check("rst_wait", "wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wait", "stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr("post_reset", mk(1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h24, 32'h0, 12, 0, 32'h0,
                                0, 1, 1, 32'h0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
